// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - servo PWM pulse-width and period decoder
//
// Purpose:
//   Measures the high time and the full period of an incoming servo PWM signal
//   in whole microseconds, publishing both once per completed period. The first
//   partial pulse seen after reset, enable or timeout is discarded.
//
// Optional feature macro:
//   PWM_CAP_FILTER_EN - when defined, a glitch filter sits after the synchronizer;
//                       the synchronized level must hold FILT_LEN cycles before it
//                       is accepted. When undefined, every transition is an edge.
//
// Ports:
//   CLK          in   1   system clock
//   RST          in   1   synchronous, active-high reset
//   PWM_IN       in   1   asynchronous PWM input
//   EN           in   1   capture enable; low forces IDLE, outputs hold
//   PULSE_WIDTH  out  32  last measured high time, us
//   PERIOD       out  32  last measured period (high+low), us
//   VALID        out  1   one-cycle strobe: PULSE_WIDTH/PERIOD/RANGE_ERR updated
//   RANGE_ERR    out  1   last PULSE_WIDTH outside [MIN_PW, MAX_PW]
//   TIMEOUT      out  1   sticky: a phase lasted TIMEOUT_US; cleared on next VALID

module pwm_capture #(
  parameter int unsigned CLK_PER_US = 100,
  parameter int unsigned MIN_PW     = 500,
  parameter int unsigned MAX_PW     = 2500,
  parameter int unsigned TIMEOUT_US = 40000,
  parameter int unsigned FILT_LEN   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PWM_IN,
  input  logic        EN,
  output logic [31:0] PULSE_WIDTH,
  output logic [31:0] PERIOD,
  output logic        VALID,
  output logic        RANGE_ERR,
  output logic        TIMEOUT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;

  logic        sync1;
  logic        sync2;
  logic        s;
  logic        s_d;
  logic        rise_q;
  logic        fall_q;

  logic [31:0] presc;
  logic [31:0] ph_cnt;
  logic [31:0] hi_hold;
  logic        wrap;
  logic [31:0] cnt_eff;
  logic        tmo_hit;

  logic        clr;
  logic        count;
  logic        latch_hi;
  logic        publish;
  logic        set_tmo;
  logic        drop_hi;

  // Two-flop synchronizer for the asynchronous input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= PWM_IN;
      sync2 <= sync1;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  logic        s_f;
  logic [31:0] filt_cnt;

  // Accept a new level only after it has been stable for FILT_LEN cycles;
  // any return to the current level restarts the qualification.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s_f      <= 1'b0;
      filt_cnt <= 32'd0;
    end else if (sync2 != s_f) begin
      if (filt_cnt == FILT_LEN - 1) begin
        s_f      <= sync2;
        filt_cnt <= 32'd0;
      end else begin
        filt_cnt <= filt_cnt + 32'd1;
      end
    end else begin
      filt_cnt <= 32'd0;
    end
  end

  assign s = s_f;
`else
  logic unused_filt_len;
  assign unused_filt_len = (FILT_LEN != 0);
  assign s = sync2;
`endif

  // Edge pulses are registered so the FSM sees a clean single-cycle strobe;
  // both edges carry the same delay, so measured widths are unaffected.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s_d    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s_d    <= s;
      rise_q <= s & ~s_d;
      fall_q <= ~s & s_d;
    end
  end

  // The current cycle belongs to the phase being measured; cnt_eff folds in the
  // microsecond it completes, giving floor(cycles / CLK_PER_US) at an edge.
  assign wrap    = (presc == CLK_PER_US - 1);
  assign cnt_eff = ph_cnt + {31'd0, wrap};
  assign tmo_hit = (state != IDLE) && (cnt_eff >= TIMEOUT_US);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Timeout is tested ahead of edges so a same-cycle edge loses to it.
  always_comb begin
    state_n  = state;
    clr      = 1'b0;
    count    = 1'b0;
    latch_hi = 1'b0;
    publish  = 1'b0;
    set_tmo  = 1'b0;
    drop_hi  = 1'b0;
    if (!EN) begin
      state_n = IDLE;
      clr     = 1'b1;
      drop_hi = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          clr = 1'b1;
          if (rise_q) begin
            state_n = HIGH;
          end
        end
        HIGH: begin
          if (tmo_hit) begin
            state_n = IDLE;
            clr     = 1'b1;
            set_tmo = 1'b1;
            drop_hi = 1'b1;
          end else if (fall_q) begin
            state_n  = LOW;
            clr      = 1'b1;
            latch_hi = 1'b1;
          end else begin
            count = 1'b1;
          end
        end
        LOW: begin
          if (tmo_hit) begin
            state_n = IDLE;
            clr     = 1'b1;
            set_tmo = 1'b1;
            drop_hi = 1'b1;
          end else if (rise_q) begin
            state_n = HIGH;
            clr     = 1'b1;
            publish = 1'b1;
          end else begin
            count = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          clr     = 1'b1;
          drop_hi = 1'b1;
        end
      endcase
    end
  end

  // Microsecond prescaler and the shared phase counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc  <= 32'd0;
      ph_cnt <= 32'd0;
    end else if (clr) begin
      presc  <= 32'd0;
      ph_cnt <= 32'd0;
    end else if (count) begin
      if (wrap) begin
        presc  <= 32'd0;
        ph_cnt <= ph_cnt + 32'd1;
      end else begin
        presc  <= presc + 32'd1;
      end
    end
  end

  // hi_hold is dropped whenever a measurement is abandoned so a later period
  // can never report a stale high time.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hi_hold <= 32'd0;
    end else if (drop_hi) begin
      hi_hold <= 32'd0;
    end else if (latch_hi) begin
      hi_hold <= cnt_eff;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      PULSE_WIDTH <= MIN_PW;
      PERIOD      <= 32'd0;
      VALID       <= 1'b0;
      RANGE_ERR   <= 1'b0;
      TIMEOUT     <= 1'b0;
    end else begin
      VALID <= publish;
      if (publish) begin
        PULSE_WIDTH <= hi_hold;
        PERIOD      <= hi_hold + cnt_eff;
        RANGE_ERR   <= (hi_hold < MIN_PW) || (hi_hold > MAX_PW);
        TIMEOUT     <= 1'b0;
      end else if (set_tmo) begin
        TIMEOUT     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard testbench for pwm_capture

module tb_pwm_capture;

  localparam int C    = 4;
  localparam int MINP = 5;
  localparam int MAXP = 25;
  localparam int TO   = 400;
  localparam int FL   = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PWM_IN;
  logic        EN;
  logic [31:0] PULSE_WIDTH;
  logic [31:0] PERIOD;
  logic        VALID;
  logic        RANGE_ERR;
  logic        TIMEOUT;

  pwm_capture #(
    .CLK_PER_US(C),
    .MIN_PW    (MINP),
    .MAX_PW    (MAXP),
    .TIMEOUT_US(TO),
    .FILT_LEN  (FL)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PWM_IN     (PWM_IN),
    .EN         (EN),
    .PULSE_WIDTH(PULSE_WIDTH),
    .PERIOD     (PERIOD),
    .VALID      (VALID),
    .RANGE_ERR  (RANGE_ERR),
    .TIMEOUT    (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pw;
    logic [31:0] per;
    logic        rerr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int tests_run = 0;
  int failed    = 0;

  // Waveform model: meas 0 = idle, 1 = measuring high, 2 = measuring low.
  int ph    = 0;
  int hi_us = 0;
  int meas  = 0;
  bit prev  = 1'b0;
  bit en_m  = 1'b1;

  logic [31:0] last_pw  = 32'(MINP);
  logic [31:0] last_per = 32'd0;

  always @(negedge CLK) begin
    if (RST === 1'b0 && VALID === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL unexpected_valid: got pw=%0d per=%0d, expected no VALID", PULSE_WIDTH, PERIOD);
      end else begin
        mon_e = sb.pop_front();
        if (PULSE_WIDTH !== mon_e.pw || PERIOD !== mon_e.per || RANGE_ERR !== mon_e.rerr || TIMEOUT !== 1'b0) begin
          failed++;
          $display("FAIL valid_result: got pw=%0d per=%0d rerr=%0b tmo=%0b, expected pw=%0d per=%0d rerr=%0b tmo=0",
                   PULSE_WIDTH, PERIOD, RANGE_ERR, TIMEOUT, mon_e.pw, mon_e.per, mon_e.rerr);
        end
        last_pw  = mon_e.pw;
        last_per = mon_e.per;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Drives lvl for n cycles. model_edge=0 marks a segment the bench expects
  // the DUT to ignore (filtered glitch): the model keeps the previous level.
  task automatic set_level(input bit lvl, input int n, input bit model_edge = 1'b1);
    bit   eff;
    exp_t e;
    eff = model_edge ? lvl : prev;
    if (eff != prev) begin
      if (eff) begin
        if (meas == 2) begin
          e.pw   = 32'(hi_us);
          e.per  = 32'(hi_us + ph / C);
          e.rerr = (hi_us < MINP) || (hi_us > MAXP);
          sb.push_back(e);
        end
        meas = en_m ? 1 : 0;
      end else begin
        if (meas == 1) begin
          hi_us = ph / C;
          meas  = 2;
        end
      end
      ph   = 0;
      prev = eff;
    end
    ph = ph + n;
    if (meas != 0 && ph >= TO * C) meas = 0;
    PWM_IN = lvl;
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse(input int hi, input int lo);
    set_level(1'b1, hi);
    set_level(1'b0, lo);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(negedge CLK);
    RST  = 1'b0;
    prev = 1'b0;
    meas = 0;
    ph   = 0;
  endtask

  task automatic check_reset_values(input string tag);
    tests_run++;
    if (PULSE_WIDTH !== 32'(MINP)) begin
      failed++;
      $display("FAIL %s_pw: got %0d, expected %0d", tag, PULSE_WIDTH, MINP);
    end
    tests_run++;
    if (PERIOD !== 32'd0) begin
      failed++;
      $display("FAIL %s_period: got %0d, expected 0", tag, PERIOD);
    end
    tests_run++;
    if (VALID !== 1'b0 || RANGE_ERR !== 1'b0 || TIMEOUT !== 1'b0) begin
      failed++;
      $display("FAIL %s_flags: got valid=%0b rerr=%0b tmo=%0b, expected 0 0 0", tag, VALID, RANGE_ERR, TIMEOUT);
    end
  endtask

  task automatic test_reset();
    RST    = 1'b1;
    EN     = 1'b1;
    PWM_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_reset_values("reset");
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) pulse(5 * C, 150 * C);
  endtask

  task automatic test_range();
    pulse(25 * C, 150 * C);
    pulse(26 * C, 150 * C);
    pulse(4 * C, 150 * C);
    pulse(5 * C, 150 * C);
  endtask

  task automatic test_timeout();
    set_level(1'b1, TO * C - 20);
    tests_run++;
    if (TIMEOUT !== 1'b0) begin
      failed++;
      $display("FAIL timeout_early: got %0b, expected 0", TIMEOUT);
    end
    set_level(1'b1, 40);
    tests_run++;
    if (TIMEOUT !== 1'b1) begin
      failed++;
      $display("FAIL timeout_set: got %0b, expected 1", TIMEOUT);
    end
    set_level(1'b0, 100);
    pulse(15 * C, 150 * C);
    tests_run++;
    if (TIMEOUT !== 1'b1) begin
      failed++;
      $display("FAIL timeout_sticky: got %0b, expected 1", TIMEOUT);
    end
    pulse(15 * C, 150 * C);
    tests_run++;
    if (TIMEOUT !== 1'b0) begin
      failed++;
      $display("FAIL timeout_clear: got %0b, expected 0", TIMEOUT);
    end
  endtask

  task automatic test_reset_mid();
    pulse(10 * C, 150 * C);
    set_level(1'b1, 20);
    do_reset();
    check_reset_values("mid_reset");
    set_level(1'b1, 10 * C - 20);
    set_level(1'b0, 150 * C);
    pulse(7 * C, 150 * C);
    pulse(7 * C, 150 * C);
  endtask

  task automatic test_enable();
    set_level(1'b1, 20);
    EN   = 1'b0;
    en_m = 1'b0;
    meas = 0;
    set_level(1'b1, 20);
    set_level(1'b0, 150 * C);
    tests_run++;
    if (PULSE_WIDTH !== last_pw || PERIOD !== last_per) begin
      failed++;
      $display("FAIL enable_hold: got pw=%0d per=%0d, expected pw=%0d per=%0d", PULSE_WIDTH, PERIOD, last_pw, last_per);
    end
    set_level(1'b1, 20);
    EN   = 1'b1;
    en_m = 1'b1;
    set_level(1'b1, 20);
    set_level(1'b0, 150 * C);
    pulse(9 * C, 150 * C);
    pulse(9 * C, 150 * C);
  endtask

  task automatic test_glitch();
`ifdef PWM_CAP_FILTER_EN
    set_level(1'b1, 20);
    set_level(1'b0, 2, 1'b0);
    set_level(1'b1, 10 * C - 22, 1'b0);
`else
    set_level(1'b1, 20);
    set_level(1'b0, 2);
    set_level(1'b1, 10 * C - 22);
`endif
    set_level(1'b0, 150 * C);
    pulse(10 * C, 150 * C);
  endtask

  task automatic test_floor();
    pulse(5 * C + 3, 150 * C + 3);
    pulse(5 * C + 3, 150 * C);
  endtask

  task automatic test_flush();
    set_level(1'b1, 30);
    tests_run++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL flush: got %0d pending results, expected 0", sb.size());
    end
    set_level(1'b0, 10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_timeout();
    test_reset_mid();
    test_enable();
    test_glitch();
    test_floor();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
